// File: rtl/pipe_stage_reg.sv
// Pipeline stage register: valid/ready handshake, flush, bubble-gated control, saturating stall counter.
// Optional second (skid) entry with registered in_ready when PIPE_STAGE_SKID_EN is defined.
module pipe_stage_reg #(
    parameter int DATA_W = 32,
    parameter int CTRL_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [CNT_W-1:0]  stall_cnt
);

    logic              m_valid_r;
    logic [DATA_W-1:0] m_data_r;
    logic [CTRL_W-1:0] m_ctrl_r;
    logic [CNT_W-1:0]  stall_cnt_r;

    logic              m_valid_s;
    logic [DATA_W-1:0] m_data_s;
    logic [CTRL_W-1:0] m_ctrl_s;
    logic              ready_s;
    logic              xfer_in_s;
    logic              xfer_out_s;

`ifdef PIPE_STAGE_SKID_EN
    logic              s_valid_r;
    logic [DATA_W-1:0] s_data_r;
    logic [CTRL_W-1:0] s_ctrl_r;
    logic              in_ready_r;
    logic              s_valid_s;
    logic [DATA_W-1:0] s_data_s;
    logic [CTRL_W-1:0] s_ctrl_s;

    assign ready_s = in_ready_r;
`else
    assign ready_s = ~m_valid_r | out_ready;
`endif

    assign xfer_in_s  = in_valid & ready_s & ~flush;
    assign xfer_out_s = m_valid_r & out_ready;

    // m_ctrl_r is kept at zero whenever m_valid_r is low, so out_ctrl needs no output gate.
    assign in_ready  = ready_s;
    assign out_valid = m_valid_r;
    assign out_data  = m_data_r;
    assign out_ctrl  = m_ctrl_r;
    assign stall_cnt = stall_cnt_r;

    // Next-state of the held entries; flush wins over every transfer.
    always_comb begin
        m_valid_s = m_valid_r;
        m_data_s  = m_data_r;
        m_ctrl_s  = m_ctrl_r;
`ifdef PIPE_STAGE_SKID_EN
        s_valid_s = s_valid_r;
        s_data_s  = s_data_r;
        s_ctrl_s  = s_ctrl_r;
        if (flush) begin
            m_valid_s = 1'b0;
            m_ctrl_s  = {CTRL_W{1'b0}};
            s_valid_s = 1'b0;
        end else if (xfer_out_s) begin
            if (s_valid_r) begin
                m_data_s  = s_data_r;
                m_ctrl_s  = s_ctrl_r;
                s_valid_s = 1'b0;
            end else if (xfer_in_s) begin
                m_data_s  = in_data;
                m_ctrl_s  = in_ctrl;
            end else begin
                m_valid_s = 1'b0;
                m_ctrl_s  = {CTRL_W{1'b0}};
            end
        end else if (xfer_in_s) begin
            if (m_valid_r) begin
                s_valid_s = 1'b1;
                s_data_s  = in_data;
                s_ctrl_s  = in_ctrl;
            end else begin
                m_valid_s = 1'b1;
                m_data_s  = in_data;
                m_ctrl_s  = in_ctrl;
            end
        end else begin
            m_valid_s = m_valid_r;
        end
`else
        if (flush) begin
            m_valid_s = 1'b0;
            m_ctrl_s  = {CTRL_W{1'b0}};
        end else if (xfer_in_s) begin
            m_valid_s = 1'b1;
            m_data_s  = in_data;
            m_ctrl_s  = in_ctrl;
        end else if (xfer_out_s) begin
            m_valid_s = 1'b0;
            m_ctrl_s  = {CTRL_W{1'b0}};
        end else begin
            m_valid_s = m_valid_r;
        end
`endif
    end

    // Entry registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid_r  <= 1'b0;
            m_data_r   <= {DATA_W{1'b0}};
            m_ctrl_r   <= {CTRL_W{1'b0}};
`ifdef PIPE_STAGE_SKID_EN
            s_valid_r  <= 1'b0;
            s_data_r   <= {DATA_W{1'b0}};
            s_ctrl_r   <= {CTRL_W{1'b0}};
            in_ready_r <= 1'b1;
`endif
        end else begin
            m_valid_r  <= m_valid_s;
            m_data_r   <= m_data_s;
            m_ctrl_r   <= m_ctrl_s;
`ifdef PIPE_STAGE_SKID_EN
            s_valid_r  <= s_valid_s;
            s_data_r   <= s_data_s;
            s_ctrl_r   <= s_ctrl_s;
            in_ready_r <= ~s_valid_s;
`endif
        end
    end

    // Saturating stall counter; only reset clears it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_r <= {CNT_W{1'b0}};
        end else if (!flush && m_valid_r && !out_ready && (stall_cnt_r != {CNT_W{1'b1}})) begin
            stall_cnt_r <= stall_cnt_r + CNT_W'(1'b1);
        end else begin
            stall_cnt_r <= stall_cnt_r;
        end
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg: directed scenarios plus random traffic
// against a queue-based model of the stage (capacity 1, or 2 with PIPE_STAGE_SKID_EN).
module tb_pipe_stage_reg;

    localparam int DW = 32;
    localparam int CW = 8;
`ifdef PIPE_STAGE_SKID_EN
    localparam int CAP = 2;
`else
    localparam int CAP = 1;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          flush = 1'b0;
    logic          in_valid = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic [CW-1:0] in_ctrl = '0;
    logic          out_ready = 1'b0;
    logic          in_ready, out_valid;
    logic [DW-1:0] out_data;
    logic [CW-1:0] out_ctrl;
    logic [15:0]   stall_cnt;
    logic          sat_in_ready, sat_out_valid;
    logic [DW-1:0] sat_out_data;
    logic [CW-1:0] sat_out_ctrl;
    logic [3:0]    sat_stall_cnt;

    int checks = 0;
    int errors = 0;

    // model: queue of held {ctrl,data}, oldest first
    logic [CW+DW-1:0] q[$];
    logic [DW-1:0]    last_data;
    int               cnt;
    int               cnt4;

    pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .CNT_W(16)) u_dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_ctrl(in_ctrl),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_ctrl(out_ctrl),
        .stall_cnt(stall_cnt)
    );

    pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .CNT_W(4)) u_sat (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(sat_in_ready), .in_data(in_data), .in_ctrl(in_ctrl),
        .out_valid(sat_out_valid), .out_ready(out_ready), .out_data(sat_out_data), .out_ctrl(sat_out_ctrl),
        .stall_cnt(sat_stall_cnt)
    );

    always #5 clk = ~clk;

    function automatic bit exp_ready();
`ifdef PIPE_STAGE_SKID_EN
        return q.size() < 2;
`else
        return (q.size() == 0) || out_ready;
`endif
    endfunction

    function automatic logic [CW-1:0] exp_ctrl();
        logic [CW+DW-1:0] e;
        if (q.size() == 0) return '0;
        e = q[0];
        return e[CW+DW-1:DW];
    endfunction

    task automatic model_reset();
        q.delete();
        last_data = '0;
        cnt = 0;
        cnt4 = 0;
    endtask

    // advance the model by one edge using the current inputs, then the DUT
    task automatic step();
        bit rdy;
        logic [CW+DW-1:0] e;
        rdy = exp_ready();
        if (flush) begin
            q.delete();
        end else begin
            if (q.size() > 0 && !out_ready) begin
                if (cnt < 65535) cnt++;
                if (cnt4 < 15) cnt4++;
            end
            if (q.size() > 0 && out_ready) void'(q.pop_front());
            if (in_valid && rdy) q.push_back({in_ctrl, in_data});
        end
        if (q.size() > 0) begin
            e = q[0];
            last_data = e[DW-1:0];
        end
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        #2;
        checks += 5;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %0b want 0", out_valid); end
        if (out_ctrl !== 8'h00) begin errors++; $display("FAIL reset_out_ctrl got %h want 00", out_ctrl); end
        if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %0b want 1", in_ready); end
        if (stall_cnt !== 16'd0) begin errors++; $display("FAIL reset_stall_cnt got %0d want 0", stall_cnt); end
        if (out_data !== 32'h0) begin errors++; $display("FAIL reset_out_data got %h want 0", out_data); end
        #10;
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_stream();
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_data = 32'h10 + i;
            in_ctrl = 8'(i + 1);
            step();
            checks += 3;
            if (out_valid !== 1'b1) begin errors++; $display("FAIL stream_valid[%0d] got %0b want 1", i, out_valid); end
            if (out_data !== 32'h10 + i) begin errors++; $display("FAIL stream_data[%0d] got %h want %h", i, out_data, 32'h10 + i); end
            if (out_ctrl !== 8'(i + 1)) begin errors++; $display("FAIL stream_ctrl[%0d] got %h want %h", i, out_ctrl, 8'(i + 1)); end
        end
        in_valid = 1'b0;
        step();
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL stream_drain got %0b want 0", out_valid); end
    endtask

    task automatic test_backpressure();
        bit bb_taken = 1'b0;
        bit acc;
        out_ready = 1'b1;
        in_valid = 1'b1; in_data = 32'hAA; in_ctrl = 8'h3C;
        step();
        out_ready = 1'b0;
        in_data = 32'hBB; in_ctrl = 8'h5A;
        for (int i = 0; i < 3; i++) begin
            in_valid = !bb_taken;
            #1;
            checks += 3;
            if (in_ready !== exp_ready()) begin errors++; $display("FAIL bp_in_ready[%0d] got %0b want %0b", i, in_ready, exp_ready()); end
            if (CAP == 1 && in_ready !== 1'b0) begin errors++; $display("FAIL bp_base_ready[%0d] got %0b want 0", i, in_ready); end
            if (out_data !== 32'hAA) begin errors++; $display("FAIL bp_hold[%0d] got %h want aa", i, out_data); end
            acc = in_valid && exp_ready();
            step();
            if (acc) bb_taken = 1'b1;
        end
        checks += 2;
        if (stall_cnt !== 16'd3) begin errors++; $display("FAIL bp_stall_cnt got %0d want 3", stall_cnt); end
        if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_full_ready got %0b want 0", in_ready); end
        out_ready = 1'b1;
        in_valid = !bb_taken;
        step();
        in_valid = 1'b0;
        checks += 2;
        if (out_data !== 32'hBB) begin errors++; $display("FAIL bp_second got %h want bb", out_data); end
        if (out_ctrl !== 8'h5A) begin errors++; $display("FAIL bp_second_ctrl got %h want 5a", out_ctrl); end
        step();
        checks += 3;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_empty got %0b want 0", out_valid); end
        if (out_ctrl !== 8'h00) begin errors++; $display("FAIL bp_gate got %h want 00", out_ctrl); end
        if (out_data !== 32'hBB) begin errors++; $display("FAIL bp_data_kept got %h want bb", out_data); end
    endtask

    task automatic test_flush();
        int cnt_before;
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (q.size() < CAP) begin
                in_valid = 1'b1; in_data = 32'(i + 1); in_ctrl = 8'hF0;
                step();
            end
        end
        cnt_before = cnt;
        flush = 1'b1; in_valid = 1'b1; in_data = 32'hCC; in_ctrl = 8'h77;
        step();
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        #1;
        checks += 4;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_valid got %0b want 0", out_valid); end
        if (out_ctrl !== 8'h00) begin errors++; $display("FAIL flush_ctrl got %h want 00", out_ctrl); end
        if (in_ready !== 1'b1) begin errors++; $display("FAIL flush_ready got %0b want 1", in_ready); end
        if (stall_cnt !== 16'(cnt_before)) begin errors++; $display("FAIL flush_stall_cnt got %0d want %0d", stall_cnt, cnt_before); end
        for (int i = 0; i < 3; i++) begin
            step();
            checks += 2;
            if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_dropped_valid[%0d] got %0b want 0", i, out_valid); end
            if (out_data === 32'hCC) begin errors++; $display("FAIL flush_dropped_data[%0d] got %h want not cc", i, out_data); end
        end
    endtask

    task automatic test_bubble();
        out_ready = 1'b1;
        in_valid = 1'b0; in_ctrl = 8'hFF; in_data = 32'h1234;
        step();
        checks++;
        if (out_ctrl !== 8'h00) begin errors++; $display("FAIL bubble_gate got %h want 00", out_ctrl); end
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        checks += 2;
        if (out_ctrl !== 8'hFF) begin errors++; $display("FAIL bubble_pass got %h want ff", out_ctrl); end
        if (out_valid !== 1'b1) begin errors++; $display("FAIL bubble_valid got %0b want 1", out_valid); end
        step();
    endtask

    task automatic test_saturation();
        pulse_reset();
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 32'h55; in_ctrl = 8'h01;
        step();
        in_valid = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            step();
            checks++;
            if (sat_stall_cnt !== 4'((i > 15) ? 15 : i)) begin
                errors++; $display("FAIL sat_cnt[%0d] got %0d want %0d", i, sat_stall_cnt, (i > 15) ? 15 : i);
            end
        end
        checks++;
        if (stall_cnt !== 16'd20) begin errors++; $display("FAIL sat_wide_cnt got %0d want 20", stall_cnt); end
    endtask

    task automatic test_async_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_data = 32'h900 + i; in_ctrl = 8'h11;
            step();
        end
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        checks += 4;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL arst_valid got %0b want 0", out_valid); end
        if (stall_cnt !== 16'd0) begin errors++; $display("FAIL arst_stall_cnt got %0d want 0", stall_cnt); end
        if (in_ready !== 1'b1) begin errors++; $display("FAIL arst_ready got %0b want 1", in_ready); end
        if (out_ctrl !== 8'h00) begin errors++; $display("FAIL arst_ctrl got %h want 00", out_ctrl); end
        #1;
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            flush = ($urandom_range(0, 15) == 0);
            in_valid = $urandom_range(0, 1);
            out_ready = ($urandom_range(0, 9) < 6);
            in_data = $urandom;
            in_ctrl = 8'($urandom);
            #1;
            checks++;
            if (in_ready !== exp_ready()) begin errors++; $display("FAIL rnd_ready[%0d] got %0b want %0b", i, in_ready, exp_ready()); end
            step();
            checks += 5;
            if (out_valid !== (q.size() != 0)) begin errors++; $display("FAIL rnd_valid[%0d] got %0b want %0b", i, out_valid, q.size() != 0); end
            if (out_data !== last_data) begin errors++; $display("FAIL rnd_data[%0d] got %h want %h", i, out_data, last_data); end
            if (out_ctrl !== exp_ctrl()) begin errors++; $display("FAIL rnd_ctrl[%0d] got %h want %h", i, out_ctrl, exp_ctrl()); end
            if (stall_cnt !== 16'(cnt)) begin errors++; $display("FAIL rnd_cnt[%0d] got %0d want %0d", i, stall_cnt, cnt); end
            if (sat_stall_cnt !== 4'(cnt4)) begin errors++; $display("FAIL rnd_cnt4[%0d] got %0d want %0d", i, sat_stall_cnt, cnt4); end
        end
        flush = 1'b0;
        in_valid = 1'b0;
    endtask

    initial begin
        model_reset();
        test_reset();
        test_stream();
        test_backpressure();
        test_flush();
        test_bubble();
        test_saturation();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised pipeline stage register with a valid/ready handshake, synchronous flush, bubble gating of control bits and a saturating stall counter. It is the generic successor to the fixed-field inter-stage buffers (IF/ID, ID/EX, EX/MEM) and is instantiated between any two pipeline stages of the CPU. Data and control fields are concatenated by the instantiating stage. The stage supports back-pressure from the downstream stage and squashing on branch or jump.

## Interface
- DATA_W, 32: width of the datapath payload (PC, operands, immediate, ALU result).
- CTRL_W, 8: width of the control payload (RegWrite, MemWrite, MemtoReg, Jump, …); forced to 0 on bubbles.
- CNT_W, 16: width of the stall counter.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous squash of all held entries.
- in_valid  in  1  upstream has a valid entry.
- in_ready  out  1  stage can accept this cycle.
- in_data  in  DATA_W  upstream datapath payload.
- in_ctrl  in  CTRL_W  upstream control payload.
- out_valid  out  1  entry presented downstream.
- out_ready  in  1  downstream accepts this cycle.
- out_data  out  DATA_W  held datapath payload.
- out_ctrl  out  CTRL_W  held control payload; 0 whenever out_valid=0.
- stall_cnt  out  CNT_W  count of cycles with out_valid=1 and out_ready=0; saturates.

## Operation
- Transfer in: in_valid & in_ready & !flush. Transfer out: out_valid & out_ready.
- Main register (m_valid, m_data, m_ctrl) drives the outputs directly.
- out_valid and in_ready are functions of the valid flags only (and, without the skid, of out_ready). They never depend on in_valid.
- Base mode: in_ready = !m_valid | out_ready.
  - On transfer in, the main register loads in_data/in_ctrl.
  - On transfer out without transfer in, m_valid clears.
- Bubble gating: out_ctrl = m_valid ? m_ctrl : 0. out_data keeps its last value when invalid; it is not cleared.
- Flush has priority over every transfer.
  - At the next edge, all valid flags clear and stall_cnt is unchanged.
  - An input presented in the flush cycle is dropped.
- stall_cnt increments each cycle with out_valid & !out_ready & !flush.
  - It holds at 2^CNT_W-1.
  - It is cleared only by reset.
- Reset (async assert, sync deassert by the integrator):
  - out_valid=0, out_data=0, out_ctrl=0, stall_cnt=0.
  - in_ready=1.
  - Skid register empty and zeroed.

## Timing
- Latency 1 cycle: data accepted at edge N is visible on out_data after edge N.
- Throughput 1 entry/cycle while out_ready=1.
- Base mode: in_ready follows out_ready combinationally (0 delay).
- Skid mode: in_ready is registered, so it has no combinational path from out_ready.
  - in_ready falls the cycle after the skid register fills.
  - in_ready rises the cycle after the skid register drains.
- Simultaneous transfer in and transfer out in the same cycle: the entry is replaced; m_valid stays 1.
- Simultaneous flush and out_ready: no output transfer is counted downstream. Downstream treats the flush cycle as don't-care.

## Configuration
- Macro: PIPE_STAGE_SKID_EN.
- Defined: a second, skid entry is added, and in_ready = !s_valid, registered.
  - The skid register captures on a transfer in while m_valid & !out_ready.
  - On a transfer out, main loads from skid if s_valid, else from the input.
  - Order is strictly FIFO; at most 2 entries are held.
- Not defined: single entry only, in_ready combinational as in Base mode, and no skid state is present.

## Test plan
- Reset then stream: with rst_n low, out_valid=0, out_ctrl=0, in_ready=1. Release reset, then drive in_data=0x10..0x14 with out_ready=1 for 5 cycles. out_data shows 0x10..0x14, one cycle later each, with no gaps.
- Back-pressure: load 0xAA, hold out_ready=0 for 3 cycles, then set it to 1.
  - out_data stays 0xAA and stall_cnt=3.
  - Base mode: in_ready=0 while stalled.
  - Skid mode: one extra entry 0xBB is accepted, then in_ready=0; 0xAA then 0xBB drain in order.
- Flush: with 2 entries held (skid mode), assert flush with in_valid=1 and in_data=0xCC. Next cycle out_valid=0, out_ctrl=0, and 0xCC is never output.
- Bubble gating: in_ctrl=0xFF with in_valid=0 for 1 cycle gives out_ctrl=0x00. With in_valid=1 in the following cycle, out_ctrl=0xFF.
- Saturation: set CNT_W=4 and hold a stall for 20 cycles. stall_cnt reaches 15 and holds there.
- Async reset mid-stall: pulse rst_n low between edges with 2 entries held. out_valid=0, stall_cnt=0 and in_ready=1 immediately, without waiting for a clock edge.
